// File: rtl/serial_receiver.sv
// serial_receiver: 8N1 asynchronous serial receive front end.
// Oversamples the synchronized line at 16x the selected baud rate, votes
// each bit from three mid-bit samples, and hands completed bytes to the
// downstream core over a valid/ready handshake. Framing errors and
// overruns are reported as single-cycle pulses.
module serial_receiver #(
    parameter int unsigned DIV0 = 651,  // 4800 baud at 50 MHz
    parameter int unsigned DIV1 = 326,  // 9600 baud
    parameter int unsigned DIV2 = 163,  // 19200 baud
    parameter int unsigned DIV3 = 81    // 38400 baud
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic [1:0] baud_sel,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Widest divisor sets the divisor counter width.
    localparam int unsigned DIV_A   = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int unsigned DIV_B   = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int unsigned DIV_TOP = (DIV_A > DIV_B) ? DIV_A : DIV_B;
    localparam int unsigned CW      = (DIV_TOP > 2) ? $clog2(DIV_TOP) : 1;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            s_meta;
    logic            s;
    logic [1:0]      cur_sel;
    logic [CW-1:0]   div_cnt;
    logic [CW-1:0]   div_last;
    logic            tick;
    logic [3:0]      samp_cnt;
    logic            bit_end;
    logic [2:0]      bit_idx;
    logic [1:0]      vote;
    logic            maj_now;
    logic            maj_q;
    logic [7:0]      shift;

    logic            start_evt;
    logic            load_evt;
    logic            ferr_evt;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b1;
            s      <= 1'b1;
        end else begin
            s_meta <= din;
            s      <= s_meta;
        end
    end

    // Baud selection is frozen at start-bit detection so mid-frame changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel <= 2'b00;
        end else if (start_evt) begin
            cur_sel <= baud_sel;
        end
    end

    // Terminal count of the divisor for the latched baud rate.
    // NOTE: every output of a combinational block gets a value on every path
    // (default or full case), otherwise synthesis infers a latch.
    always_comb begin
        case (cur_sel)
            2'b00:   div_last = CW'(DIV0 - 1);
            2'b01:   div_last = CW'(DIV1 - 1);
            2'b10:   div_last = CW'(DIV2 - 1);
            default: div_last = CW'(DIV3 - 1);
        endcase
    end

    assign tick    = (state != IDLE) && (div_cnt == div_last);
    assign bit_end = tick && (samp_cnt == 4'd15);
    assign maj_now = (vote[0] & vote[1]) | (vote[0] & s) | (vote[1] & s);
    assign busy    = (state != IDLE);

    // Divisor counter: held at zero in IDLE so a frame's first tick is a full DIV after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Sample counter: tick position within a bit, or run of high ticks in WAIT_HIGH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt <= 4'd0;
        end else if (state_nxt != state) begin
            samp_cnt <= 4'd0;
        end else if (state == WAIT_HIGH && !s) begin
            samp_cnt <= 4'd0;
        end else if (tick) begin
            samp_cnt <= samp_cnt + 4'd1;
        end
    end

    // Data bit index, cleared while the start bit is being qualified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 3'd0;
        end else if (state == START) begin
            bit_idx <= 3'd0;
        end else if (state == DATA && bit_end) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Mid-bit voting: samples at ticks 7 and 8 are stored, tick 9 resolves the majority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote  <= 2'b00;
            maj_q <= 1'b0;
        end else if (tick) begin
            case (samp_cnt)
                4'd7:    vote[0] <= s;
                4'd8:    vote[1] <= s;
                4'd9:    maj_q   <= maj_now;
                default: ;
            endcase
        end
    end

    // Receive shift register, LSB first: each voted bit enters at the top.
    // NOTE: this is an ordinary register, not a memory array, so it takes the
    // async reset like every other flop and never shows X downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= 8'h00;
        end else if (state == DATA && bit_end) begin
            shift <= {maj_q, shift[7:1]};
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_HIGH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and single-cycle frame events.
    always_comb begin
        state_nxt = state;
        start_evt = 1'b0;
        load_evt  = 1'b0;
        ferr_evt  = 1'b0;
        case (state)
            WAIT_HIGH: begin
                // Sixteen consecutive high ticks prove the line is idle, not mid-frame.
                if (tick && s && samp_cnt == 4'd15) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (!s) begin
                    state_nxt = START;
                    start_evt = 1'b1;
                end
            end
            START: begin
                // A start bit that votes high was a glitch; drop it silently.
                if (bit_end) begin
                    state_nxt = maj_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Decide at mid stop bit so the next start edge is not missed.
                if (tick && samp_cnt == 4'd9) begin
                    if (maj_now) begin
                        load_evt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_evt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            default: state_nxt = WAIT_HIGH;
        endcase
    end

    // Output holding register, handshake and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_evt;
            // A byte accepted in the same cycle as a new load is not lost.
            overrun   <= load_evt && valid && !ready;
            if (load_evt) begin
                data  <= shift;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: scoreboard bench for serial_receiver.
// Divisors are scaled down (same 8:4:2:1 spacing) to keep run length short.
module tb_serial_receiver;

    localparam int DIV0 = 40;
    localparam int DIV1 = 20;
    localparam int DIV2 = 10;
    localparam int DIV3 = 5;
    localparam int BT0  = 16 * DIV0;
    localparam int BT3  = 16 * DIV3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       din      = 1'b1;
    logic [1:0] baud_sel = 2'b00;
    logic       ready    = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks       = 0;
    int errors       = 0;
    int valid_cycles = 0;
    int ferr_cnt     = 0;
    int ovr_cnt      = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    serial_receiver #(
        .DIV0(DIV0),
        .DIV1(DIV1),
        .DIV2(DIV2),
        .DIV3(DIV3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .baud_sel (baud_sel),
        .ready    (ready),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: counts pulses and pops the scoreboard on each accept.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid)     valid_cycles++;
            if (frame_err) ferr_cnt++;
            if (overrun)   ovr_cnt++;
            if (valid && ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL accept_unexpected got=%h exp=none", data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (data !== mon_exp) begin
                        errors++;
                        $display("FAIL accept_data got=%h exp=%h", data, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int bt);
        din = v;
        wait_cycles(bt);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bt, input logic stop_v, input bit toggle);
        drive_bit(1'b0, bt);
        for (int i = 0; i < 8; i++) begin
            if (toggle && (i == 2 || i == 6)) baud_sel = ~baud_sel;
            drive_bit(b[i], bt);
        end
        drive_bit(stop_v, bt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = 1'b1; ready = 1'b0; baud_sel = 2'b00;
        #20;
        checks++; if (data !== 8'h00)    begin errors++; $display("FAIL rst_data got=%h exp=00", data); end
        checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL rst_valid got=%b exp=0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL rst_busy got=%b exp=1", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_cycles(BT0 / 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_high_busy got=%b exp=1", busy); end
        wait_cycles(BT0 / 2 + 60);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        int v0, f0, o0;
        baud_sel = 2'b00; ready = 1'b1;
        v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h63);
        send_frame(8'h63, BT0, 1'b1, 1'b0);
        wait_cycles(4);
        checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL basic_valid_pulse got=%0d exp=1", valid_cycles - v0); end
        checks++; if (ferr_cnt != f0)  begin errors++; $display("FAIL basic_frame_err got=%0d exp=%0d", ferr_cnt, f0); end
        checks++; if (ovr_cnt != o0)   begin errors++; $display("FAIL basic_overrun got=%0d exp=%0d", ovr_cnt, o0); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL basic_busy got=%b exp=0", busy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_sb_empty got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_overrun();
        int o0;
        ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h63, BT0, 1'b1, 1'b0);
        checks++; if (data !== 8'h63) begin errors++; $display("FAIL ovr_first_data got=%h exp=63", data); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got=%b exp=1", valid); end
        drive_bit(1'b1, 5 * BT0);
        // First byte is overwritten, so only the second is expected at the consumer.
        exp_q.push_back(8'h8E);
        send_frame(8'h8E, BT0, 1'b1, 1'b0);
        wait_cycles(20);
        checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", ovr_cnt - o0); end
        checks++; if (data !== 8'h8E)    begin errors++; $display("FAIL ovr_second_data got=%h exp=8e", data); end
        checks++; if (valid !== 1'b1)    begin errors++; $display("FAIL ovr_valid_held got=%b exp=1", valid); end
        ready = 1'b1;
        wait_cycles(3);
        checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL ovr_valid_drop got=%b exp=0", valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovr_sb_empty got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        ready = 1'b1; baud_sel = 2'b00;
        v0 = valid_cycles; f0 = ferr_cnt;
        send_frame(8'hA5, BT0, 1'b0, 1'b0);
        checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulse got=%0d exp=1", ferr_cnt - f0); end
        checks++; if (data !== 8'h8E)     begin errors++; $display("FAIL ferr_data_kept got=%h exp=8e", data); end
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL ferr_valid_kept got=%b exp=0", valid); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL ferr_busy got=%b exp=1", busy); end
        // Too short a high period, then a frame that must be ignored.
        drive_bit(1'b1, 3 * DIV0);
        send_frame(8'h00, BT0, 1'b1, 1'b0);
        drive_bit(1'b1, 2 * BT0);
        checks++; if (ferr_cnt - f0 != 1)    begin errors++; $display("FAIL ignored_ferr got=%0d exp=1", ferr_cnt - f0); end
        checks++; if (valid_cycles != v0)   begin errors++; $display("FAIL ignored_valid got=%0d exp=%0d", valid_cycles, v0); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL ignored_busy got=%b exp=0", busy); end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, BT0, 1'b1, 1'b0);
        wait_cycles(10);
        checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL recover_valid got=%0d exp=1", valid_cycles - v0); end
        checks++; if (exp_q.size() != 0)      begin errors++; $display("FAIL recover_sb_empty got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_glitch();
        int v0, f0, n;
        v0 = valid_cycles; f0 = ferr_cnt;
        baud_sel = 2'b00;
        din = 1'b0;
        wait_cycles(20);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got=%b exp=1", busy); end
        wait_cycles(164);
        din = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < BT0) begin
            wait_cycles(1);
            n++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_timeout got=%b exp=0", busy); end
        wait_cycles(BT0);
        checks++; if (valid_cycles != v0) begin errors++; $display("FAIL glitch_valid got=%0d exp=%0d", valid_cycles, v0); end
        checks++; if (ferr_cnt != f0)     begin errors++; $display("FAIL glitch_ferr got=%0d exp=%0d", ferr_cnt, f0); end
    endtask

    task automatic test_back_to_back();
        int v0;
        baud_sel = 2'b11; ready = 1'b1;
        wait_cycles(10);
        v0 = valid_cycles;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, BT3, 1'b1, 1'b1);
        send_frame(8'hFF, BT3, 1'b1, 1'b1);
        wait_cycles(10);
        checks++; if (valid_cycles - v0 != 2) begin errors++; $display("FAIL b2b_valid got=%0d exp=2", valid_cycles - v0); end
        checks++; if (data !== 8'hFF)         begin errors++; $display("FAIL b2b_last_data got=%h exp=ff", data); end
        checks++; if (exp_q.size() != 0)      begin errors++; $display("FAIL b2b_sb_empty got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_midframe();
        int v0, f0;
        logic [7:0] b;
        b = 8'hC3;
        baud_sel = 2'b11; ready = 1'b1;
        drive_bit(1'b0, BT3);
        for (int i = 0; i < 4; i++) drive_bit(b[i], BT3);
        din = b[4];
        wait_cycles(BT3 / 2);
        rst_n = 1'b0;
        #1;
        checks++; if (data !== 8'h00)     begin errors++; $display("FAIL mid_rst_data got=%h exp=00", data); end
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", valid); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL mid_rst_busy got=%b exp=1", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mid_rst_ferr got=%b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL mid_rst_overrun got=%b exp=0", overrun); end
        wait_cycles(BT3 / 2);
        rst_n = 1'b1;
        v0 = valid_cycles; f0 = ferr_cnt;
        for (int i = 5; i < 8; i++) drive_bit(b[i], BT3);
        drive_bit(1'b1, BT3);
        wait_cycles(BT0 + 100);
        checks++; if (valid_cycles != v0) begin errors++; $display("FAIL mid_no_byte got=%0d exp=%0d", valid_cycles, v0); end
        checks++; if (ferr_cnt != f0)     begin errors++; $display("FAIL mid_no_ferr got=%0d exp=%0d", ferr_cnt, f0); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_idle got=%b exp=0", busy); end
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, BT3, 1'b1, 1'b0);
        wait_cycles(10);
        checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL mid_next_valid got=%0d exp=1", valid_cycles - v0); end
        checks++; if (data !== 8'hC3)         begin errors++; $display("FAIL mid_next_data got=%h exp=c3", data); end
        checks++; if (exp_q.size() != 0)      begin errors++; $display("FAIL mid_sb_empty got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
Asynchronous serial (UART-style) receive front end that sits directly upstream of the serial transceiver core. It samples the raw idle-high `din` line at 16x the selected baud rate and recovers 8N1 frames. Each recovered byte goes to the core over a valid/ready handshake. Framing and overrun errors are reported as one-cycle pulses.

Parameters:
DIV0, 651, clocks per 16x sample tick for baud_sel=00 (4800 baud at 50 MHz; bit time 10416 clk)
DIV1, 326, sample-tick divisor for baud_sel=01 (9600 baud)
DIV2, 163, sample-tick divisor for baud_sel=10 (19200 baud)
DIV3, 81, sample-tick divisor for baud_sel=11 (38400 baud)

Ports:
clk        input   1  system clock, 50 MHz, rising edge
rst_n      input   1  asynchronous active-low reset
din        input   1  raw serial line, idle high, asynchronous to clk
baud_sel   input   2  baud select; latched at start-bit detection
ready      input   1  consumer accepts data when valid&ready
data       output  8  received byte, LSB received first
valid      output  1  data holds an unaccepted byte
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun    output  1  one-cycle pulse: a completed byte overwrote an unaccepted one
busy       output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous, active-low (rst_n).
- Input path: din passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `s`.
- Reset values: data=0, valid=0, frame_err=0, overrun=0, busy=1. State=WAIT_HIGH, counters=0.
- Sample tick: a divisor counter counts 0..DIV-1 and pulses `tick` on DIV-1.
  - DIV comes from baud_sel captured on entry to START; baud_sel changes mid-frame are ignored.
  - The counter restarts at 0 on the IDLE->START transition.
- Sample counter: 4-bit, counts ticks 0..15 within each bit. Bit value = majority of `s` at ticks 7, 8 and 9.
- States:
  - WAIT_HIGH: stays until `s`=1 for 16 consecutive ticks (DIV0 rate until a frame has latched a selection), then -> IDLE. This prevents a reset mid-frame from decoding garbage.
  - IDLE: busy=0. On `s`=0 -> START.
  - START: at tick 15 of the start bit, majority=1 (glitch) -> IDLE with no outputs; majority=0 -> DATA with bit index 0.
  - DATA: at tick 15, shift the majority bit into shift[7] (right shift, LSB first). After bit index 7 -> STOP.
  - STOP: at tick 9 (mid stop bit), evaluate majority:
    - Majority=1: load data<=shift and set valid. If valid was already 1 and ready=0 in that cycle, pulse overrun for 1 cycle (new byte overwrites old). Then -> IDLE. Returning at mid stop bit allows back-to-back frames.
    - Majority=0: pulse frame_err, discard the byte (data and valid unchanged), -> WAIT_HIGH. A break condition is therefore consumed silently.
- Handshake: valid falls the cycle after valid&ready.
  - Load and accept in the same cycle: the old byte is accepted, the new byte is loaded, valid stays 1, no overrun.
  - ready while valid=0 has no effect.
- Latency: valid rises 2 (sync) + 1 + (9*16+9)*DIV ± DIV clocks after the din falling edge. At 4800 baud this is ≈99,600 clk.
- Tolerance: correct decode with up to ±3% baud mismatch.

Test Plan:
- Reset, then din idle 300,000 clk. Send the 4800-baud frame start 0, data 1,1,0,0,0,1,1,0, stop 1 (10416 clk/bit), ready=1 -> valid pulses 1 cycle with data=8'h63. frame_err=0, overrun=0, busy returns to 0.
- With ready held 0, send 8'h63 and then, 80,000 clk after the first frame's stop bit, a second frame with data bits 0,1,1,1,0,0,0,1 -> second completion pulses overrun, data=8'h8E, valid stays 1 until ready.
- Stop bit forced 0 on a frame carrying 8'hA5 -> frame_err pulses once, data and valid unchanged. A frame sent before din has been high 16 ticks is ignored; the next valid frame decodes correctly.
- Start glitch: din low for 3,000 clk then high at 4800 baud -> no valid, no frame_err, busy returns to 0 within 10416 clk.
- baud_sel=11, back-to-back frames 8'h00 then 8'hFF (1296 clk/bit) with ready=1 -> two valid pulses, data 8'h00 then 8'hFF. Toggling baud_sel mid-frame does not corrupt decode.
- Assert rst_n low during data bit 4 of a frame -> all outputs go to reset values immediately. No byte is emitted for the remainder of the frame, and the next full frame decodes correctly.
